// File: rtl/reg_bank_pkg.sv
// Shared encodings for the multi-port register bank: operation codes, FSM states
// and the log2 helper used to size address and source-select fields.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_SWAP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP2 = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_src_mux.sv
// WRITE source selector: external channels, then cu_const, then alu_out; every
// higher select value picks the register-to-register move operand. Combinational.
module reg_bank_src_mux
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 2,
  localparam int SEL_W     = clog2(N_IN + 3)
) (
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]      cu_const,
  input  logic [DATA_WIDTH-1:0]      alu_out,
  input  logic [DATA_WIDTH-1:0]      move_data,
  input  logic [SEL_W-1:0]           sel,
  output logic [DATA_WIDTH-1:0]      sel_data
);

  always_comb begin
    sel_data = move_data;
    if (sel == SEL_W'(N_IN))     sel_data = cu_const;
    if (sel == SEL_W'(N_IN + 1)) sel_data = alu_out;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Register bank with single-cycle WRITE, two-cycle SWAP and N_REGS-cycle CLEAR sweep.
// rd_data is registered write-first (1 cycle); op_ready drops while SWAP/CLEAR run.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REGS     = 16,
  parameter int N_IN       = 2,
  parameter int OUT_IDX    = 0,
  parameter int ALUA_IDX   = 1,
  parameter int ALUB_IDX   = 2,
  localparam int ADDR_W    = clog2(N_REGS),
  localparam int SEL_W     = clog2(N_IN + 3)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]      cu_const,
  input  logic [DATA_WIDTH-1:0]      alu_out,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 op,
  input  logic [SEL_W-1:0]           src_sel,
  input  logic [ADDR_W-1:0]          dst_addr,
  input  logic [ADDR_W-1:0]          src_addr,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [DATA_WIDTH-1:0]      out,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  output logic                       busy,
  output logic                       done
);

  logic [DATA_WIDTH-1:0] regs_q [N_REGS];
  logic [DATA_WIDTH-1:0] regs_d [N_REGS];
  logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]     swap_addr_q, swap_addr_d;
  logic [ADDR_W-1:0]     sweep_q, sweep_d;
  logic                  done_q, done_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] wr_data;

  reg_bank_src_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_IN       (N_IN)
  ) u_src_mux (
    .in_data   (in_data),
    .cu_const  (cu_const),
    .alu_out   (alu_out),
    .move_data (regs_q[src_addr]),
    .sel       (src_sel),
    .sel_data  (wr_data)
  );

  always_comb begin
    regs_d      = regs_q;
    tmp_d       = tmp_q;
    swap_addr_d = swap_addr_q;
    sweep_d     = sweep_q;
    state_d     = state_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_e'(op))
            OP_WRITE: regs_d[dst_addr] = wr_data;
            OP_SWAP: begin
              regs_d[dst_addr] = regs_q[src_addr];
              tmp_d            = regs_q[dst_addr];
              swap_addr_d      = src_addr;
              state_d          = ST_SWAP2;
            end
            OP_CLEAR: begin
              sweep_d = '0;
              state_d = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
      ST_SWAP2: begin
        // Equal addresses restore the original value here, so same-register swaps are no-ops.
        regs_d[swap_addr_q] = tmp_q;
        done_d              = 1'b1;
        state_d             = ST_IDLE;
      end
      ST_CLEAR: begin
        regs_d[sweep_q] = '0;
        sweep_d         = sweep_q + 1'b1;
        if (sweep_q == ADDR_W'(N_REGS - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_data_d = regs_d[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      tmp_q       <= '0;
      rd_data_q   <= '0;
      swap_addr_q <= '0;
      sweep_q     <= '0;
      done_q      <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      regs_q      <= regs_d;
      tmp_q       <= tmp_d;
      rd_data_q   <= rd_data_d;
      swap_addr_q <= swap_addr_d;
      sweep_q     <= sweep_d;
      done_q      <= done_d;
      state_q     <= state_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign out      = regs_q[OUT_IDX];
  assign alu_a    = regs_q[ALUA_IDX];
  assign alu_b    = regs_q[ALUB_IDX];

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp (DW=8, N_REGS=16, N_IN=2): WRITE sources, SWAP,
// CLEAR sweep, write-first read port and reset aborting a sweep.
module tb_reg_bank_mp;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_data;
  logic [7:0]  cu_const;
  logic [7:0]  alu_out;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op;
  logic [2:0]  src_sel;
  logic [3:0]  dst_addr;
  logic [3:0]  src_addr;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  out;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  reg_bank_mp dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .cu_const (cu_const),
    .alu_out  (alu_out),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .src_sel  (src_sel),
    .dst_addr (dst_addr),
    .src_addr (src_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out      (out),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ch0(input logic [3:0] dst, input logic [7:0] val);
    in_data  = {8'h00, val};
    src_sel  = 3'd0;
    dst_addr = dst;
    op       = 2'd1;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    op_valid = 1'b0;
    rd_addr  = addr;
    step();
    check($sformatf("%s[%0d]", tag, addr), rd_data, exp);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_data  = '0;
    cu_const = '0;
    alu_out  = '0;
    op_valid = 1'b0;
    op       = 2'd0;
    src_sel  = '0;
    dst_addr = '0;
    src_addr = '0;
    rd_addr  = '0;

    #12;
    check("rst_out", out, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // WRITE from cu_const into the alu_a tap
    cu_const = 8'h5A; src_sel = 3'd2; dst_addr = 4'd1; op = 2'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("wr_const_alu_a", alu_a, 8'h5A);
    check("wr_const_busy", busy, 1'b0);
    check("wr_const_done", done, 1'b0);

    // Write-first read of the address written on the same edge
    rd_addr = 4'd5;
    write_ch0(4'd5, 8'h3C);
    check("rd_write_first", rd_data, 8'h3C);

    // Channel 1, alu_out, then a move (src_sel=4 and src_sel=7)
    in_data = 16'h9E00; src_sel = 3'd1; dst_addr = 4'd0; op = 2'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("wr_ch1_out", out, 8'h9E);
    alu_out = 8'h77; src_sel = 3'd3; dst_addr = 4'd4; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check_reg("wr_alu_out", 4'd4, 8'h77);
    src_sel = 3'd4; src_addr = 4'd0; dst_addr = 4'd2; op = 2'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("move_alu_b", alu_b, 8'h9E);
    src_sel = 3'd7; src_addr = 4'd4; dst_addr = 4'd6; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check_reg("move_sel7", 4'd6, 8'h77);

    // NOP leaves the bank alone
    op = 2'd0; dst_addr = 4'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("nop_alu_a", alu_a, 8'h5A);

    // SWAP reg3 <-> reg7; a WRITE offered while busy must be dropped
    write_ch0(4'd3, 8'h11);
    write_ch0(4'd7, 8'h22);
    op = 2'd2; src_addr = 4'd3; dst_addr = 4'd7; rd_addr = 4'd7; op_valid = 1'b1;
    step();
    check("swap1_rd_dst", rd_data, 8'h11);
    check("swap1_busy", busy, 1'b1);
    check("swap1_op_ready", op_ready, 1'b0);
    check("swap1_done", done, 1'b0);
    op = 2'd1; src_sel = 3'd2; cu_const = 8'hEE; dst_addr = 4'd1; rd_addr = 4'd3;
    step();
    op_valid = 1'b0;
    check("swap2_rd_src", rd_data, 8'h22);
    check("swap2_done", done, 1'b1);
    check("swap2_op_ready", op_ready, 1'b1);
    step();
    check("swap_done_pulse", done, 1'b0);
    check("swap_ignored_wr", alu_a, 8'h5A);
    check_reg("swap_reg", 4'd3, 8'h22);
    check_reg("swap_reg", 4'd7, 8'h11);

    // SWAP with equal addresses is a two-cycle no-op
    op = 2'd2; src_addr = 4'd3; dst_addr = 4'd3; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("swap_eq_busy", busy, 1'b1);
    step();
    check("swap_eq_done", done, 1'b1);
    check_reg("swap_eq_reg", 4'd3, 8'h22);

    // CLEAR sweep over a bank of 0xFF while WRITEs are offered every cycle
    for (int i = 0; i < 16; i++) write_ch0(4'(i), 8'hFF);
    op = 2'd3; op_valid = 1'b1;
    step();
    op = 2'd1; src_sel = 3'd0; in_data = 16'h00AB; dst_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clr_busy_%0d", i), busy, 1'b1);
      step();
      check($sformatf("clr_done_%0d", i), done, (i == 15) ? 1'b1 : 1'b0);
    end
    op_valid = 1'b0;
    check("clr_end_busy", busy, 1'b0);
    check("clr_out", out, 8'h00);
    for (int i = 0; i < 16; i++) check_reg("clr_reg", 4'(i), 8'h00);

    // Reset part-way through a sweep (at index 8)
    for (int i = 0; i < 16; i++) write_ch0(4'(i), 8'hFF);
    op = 2'd3; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("abort_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    #2;
    check("abort_busy", busy, 1'b0);
    check("abort_op_ready", op_ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_alu_b", alu_b, 8'h00);
    #1;
    reset_n = 1'b1;
    cu_const = 8'h42; src_sel = 3'd2; dst_addr = 4'd1; op = 2'd1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("post_rst_wr", alu_a, 8'h42);
    check("post_rst_done", done, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    for (int i = 8; i < 16; i++) check_reg("abort_reg", 4'(i), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
